// File: rtl/pss_peak_tracker.sv
// PSS decision/tracking stage: arbitrates the per-N_id_2 peak streams, tracks the
// SSB period in TRACK mode and fires a one-shot start to the CFO estimator.

module pss_peak_tracker_lane #(
   parameter int SCORE_DW = 32
) (
   input  logic                i_en,
   input  logic                i_peak,
   input  logic [SCORE_DW-1:0] i_score,
   input  logic [SCORE_DW-1:0] i_thresh,
   output logic                o_cand
);
   assign o_cand = i_en & i_peak & (i_score >= i_thresh);
endmodule

module pss_peak_tracker #(
   parameter  int NUM_CH       = 3,
   parameter  int SCORE_DW     = 32,
   parameter  int SSB_INTERVAL = 38400,
   parameter  int TRACK_TOL    = 100,
   parameter  int MAX_MISSES   = 3,
   localparam int ID_DW        = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1,
   localparam int TE_DW        = $clog2(TRACK_TOL) + 2,
   localparam int MISS_W       = $clog2(MAX_MISSES + 1)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       s_axis_in_tvalid,
   input  logic [NUM_CH-1:0]          peak_detected_i,
   input  logic [NUM_CH*SCORE_DW-1:0] score_i,
   input  logic [SCORE_DW-1:0]        score_thresh_i,
   input  logic [1:0]                 mode_i,
   input  logic [ID_DW-1:0]           requested_N_id_2_i,
   output logic                       correlator_en_o,
   output logic [ID_DW-1:0]           N_id_2_o,
   output logic                       N_id_2_valid_o,
   output logic                       locked_o,
   output logic [TE_DW-1:0]           timing_err_o,
   output logic [MISS_W-1:0]          miss_cnt_o,
   output logic                       cfo_start_o,
   input  logic                       cfo_busy_i
);

   localparam int CNT_W = $clog2(SSB_INTERVAL + TRACK_TOL + 1);
   localparam logic [CNT_W-1:0]  WIN_LO   = CNT_W'(SSB_INTERVAL - TRACK_TOL);
   localparam logic [CNT_W-1:0]  WIN_HI   = CNT_W'(SSB_INTERVAL + TRACK_TOL);
   localparam logic [CNT_W-1:0]  RECENTRE = CNT_W'(TRACK_TOL);
   localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MAX_MISSES - 1);

   localparam logic [1:0] MODE_SEARCH = 2'd0;
   localparam logic [1:0] MODE_FIND   = 2'd1;
   localparam logic [1:0] MODE_PAUSE  = 2'd2;

   typedef enum logic [2:0] {ST_IDLE, ST_SRCH, ST_FND, ST_ACQ, ST_LOCK} state_t;

   state_t                r_state, w_nxt_state;
   logic [1:0]            r_mode_q;
   logic                  r_init;
   logic [CNT_W-1:0]      r_cnt, w_nxt_cnt;
   logic [MISS_W-1:0]     r_miss, w_nxt_miss;
   logic                  r_locked, w_nxt_locked;
   logic [ID_DW-1:0]      r_lock_id, w_nxt_lock_id;
   logic [TE_DW-1:0]      r_te, w_nxt_te;
   logic [ID_DW-1:0]      r_id;
   logic                  r_vld, r_cfo, r_cor_en;

   logic [NUM_CH-1:0][SCORE_DW-1:0] w_score;
   logic [NUM_CH-1:0]               w_cand;
   logic                            w_any, w_req_hit, w_lock_hit, w_in_win, w_force;
   logic [ID_DW-1:0]                w_win, w_acc_id;
   logic [SCORE_DW-1:0]             w_best;
   logic                            w_acc;
   logic [TE_DW-1:0]                w_te;

   assign w_score = score_i;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      pss_peak_tracker_lane #(.SCORE_DW(SCORE_DW)) u_lane (
         .i_en     (r_cor_en),
         .i_peak   (peak_detected_i[k]),
         .i_score  (w_score[k]),
         .i_thresh (score_thresh_i),
         .o_cand   (w_cand[k])
      );
   end

   // Strict '>' keeps the lowest index on equal scores.
   always_comb begin
      w_any      = 1'b0;
      w_win      = '0;
      w_best     = '0;
      w_req_hit  = 1'b0;
      w_lock_hit = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (w_cand[k] && (!w_any || w_score[k] > w_best)) begin
            w_any  = 1'b1;
            w_win  = ID_DW'(k);
            w_best = w_score[k];
         end
         w_req_hit  = w_req_hit  | (w_cand[k] & (requested_N_id_2_i == ID_DW'(k)));
         w_lock_hit = w_lock_hit | (w_cand[k] & (r_lock_id == ID_DW'(k)));
      end
   end

   assign w_in_win = (r_cnt >= WIN_LO) && (r_cnt <= WIN_HI);
   // Error is bounded by TRACK_TOL, so modular arithmetic in TE_DW bits is exact.
   assign w_te     = TE_DW'(r_cnt) - TE_DW'(SSB_INTERVAL);
   assign w_force  = r_init | (mode_i != r_mode_q);

   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_cnt     = r_cnt;
      w_nxt_miss    = r_miss;
      w_nxt_locked  = r_locked;
      w_nxt_lock_id = r_lock_id;
      w_nxt_te      = r_te;
      w_acc         = 1'b0;
      w_acc_id      = w_win;
      if (w_force) begin
         case (mode_i)
            MODE_PAUSE:  w_nxt_state = ST_IDLE;
            MODE_SEARCH: w_nxt_state = ST_SRCH;
            MODE_FIND:   w_nxt_state = ST_FND;
            default:     w_nxt_state = ST_ACQ;
         endcase
         w_nxt_locked = 1'b0;
         w_nxt_miss   = '0;
         w_nxt_cnt    = '0;
      end else begin
         case (r_state)
            ST_SRCH: w_acc = w_any;
            ST_FND: begin
               w_acc    = w_req_hit;
               w_acc_id = requested_N_id_2_i;
            end
            ST_ACQ: begin
               if (w_any) begin
                  w_acc         = 1'b1;
                  w_nxt_lock_id = w_win;
                  w_nxt_cnt     = '0;
                  w_nxt_miss    = '0;
                  w_nxt_locked  = 1'b1;
                  w_nxt_state   = ST_LOCK;
               end
            end
            ST_LOCK: begin
               // An accepted peak takes precedence over a coincident window expiry.
               if (w_lock_hit && w_in_win) begin
                  w_acc      = 1'b1;
                  w_acc_id   = r_lock_id;
                  w_nxt_te   = w_te;
                  w_nxt_cnt  = '0;
                  w_nxt_miss = '0;
               end else if (s_axis_in_tvalid) begin
                  if (r_cnt == WIN_HI) begin
                     w_nxt_cnt = RECENTRE;
                     if (r_miss == MISS_LIM) begin
                        w_nxt_miss   = '0;
                        w_nxt_locked = 1'b0;
                        w_nxt_state  = ST_ACQ;
                     end else begin
                        w_nxt_miss = r_miss + MISS_W'(1);
                     end
                  end else begin
                     w_nxt_cnt = r_cnt + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state   <= ST_IDLE;
         r_mode_q  <= '0;
         r_init    <= 1'b1;
         r_cnt     <= '0;
         r_miss    <= '0;
         r_locked  <= 1'b0;
         r_lock_id <= '0;
         r_te      <= '0;
         r_id      <= '0;
         r_vld     <= 1'b0;
         r_cfo     <= 1'b0;
         r_cor_en  <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_mode_q  <= mode_i;
         r_init    <= 1'b0;
         r_cnt     <= w_nxt_cnt;
         r_miss    <= w_nxt_miss;
         r_locked  <= w_nxt_locked;
         r_lock_id <= w_nxt_lock_id;
         r_te      <= w_nxt_te;
         if (w_acc) r_id <= w_acc_id;
         r_vld     <= w_acc;
         r_cfo     <= w_acc & ~cfo_busy_i;
         r_cor_en  <= (w_nxt_state != ST_IDLE);
      end
   end

   assign correlator_en_o = r_cor_en;
   assign N_id_2_o        = r_id;
   assign N_id_2_valid_o  = r_vld;
   assign locked_o        = r_locked;
   assign timing_err_o    = r_te;
   assign miss_cnt_o      = r_miss;
   assign cfo_start_o     = r_cfo;

endmodule

// File: tb/tb_pss_peak_tracker.sv
// Directed + randomized bench for pss_peak_tracker, checked every cycle against a
// rule-level model of search/find/track behaviour.

module tb_pss_peak_tracker;
   localparam int NUM_CH = 3, SCORE_DW = 32, SSB = 200, TOL = 10, MAXM = 3, THR = 50;
   localparam int ID_DW = 2, TE_DW = 6, MISS_W = 2;

   logic                       clk = 1'b0;
   logic                       reset_i, tvalid, busy;
   logic [NUM_CH-1:0]          peak;
   logic [NUM_CH*SCORE_DW-1:0] score;
   logic [SCORE_DW-1:0]        thresh;
   logic [1:0]                 mode;
   logic [ID_DW-1:0]           req;
   logic                       cor_en, vld, locked, cfo;
   logic [ID_DW-1:0]           nid;
   logic [TE_DW-1:0]           te;
   logic [MISS_W-1:0]          miss;

   always #5 clk = ~clk;

   pss_peak_tracker #(.NUM_CH(NUM_CH), .SCORE_DW(SCORE_DW), .SSB_INTERVAL(SSB),
                      .TRACK_TOL(TOL), .MAX_MISSES(MAXM)) dut (
      .clk_i(clk), .reset_i(reset_i), .s_axis_in_tvalid(tvalid),
      .peak_detected_i(peak), .score_i(score), .score_thresh_i(thresh),
      .mode_i(mode), .requested_N_id_2_i(req), .correlator_en_o(cor_en),
      .N_id_2_o(nid), .N_id_2_valid_o(vld), .locked_o(locked), .timing_err_o(te),
      .miss_cnt_o(miss), .cfo_start_o(cfo), .cfo_busy_i(busy));

   int n_assert = 0, n_fail = 0;

   // Model: mode last applied (-1 = none since reset), lock status, samples since
   // the last anchor point, consecutive misses, last reported values.
   int m_mode, m_lock_id, m_cnt, m_miss, m_te, m_id;
   bit m_en, m_locked, e_vld, e_cfo;

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sc(input int k);
      return score[k*32 +: 32];
   endfunction

   function automatic bit is_cand(input int k);
      return m_en && peak[k] && (sc(k) >= thresh);
   endfunction

   task automatic model_reset();
      m_mode = -1; m_en = 0; m_locked = 0; m_lock_id = 0; m_cnt = 0;
      m_miss = 0; m_te = 0; m_id = 0; e_vld = 0; e_cfo = 0;
   endtask

   task automatic model_cycle();
      int best, aid;
      bit acc;
      if (reset_i) begin model_reset(); return; end
      e_vld = 0; e_cfo = 0; acc = 0; aid = 0;
      if (int'(mode) != m_mode) begin
         m_mode = int'(mode); m_en = (mode != 2'd2);
         m_locked = 0; m_miss = 0; m_cnt = 0;
         return;
      end
      best = -1;
      for (int k = 0; k < NUM_CH; k++)
         if (is_cand(k) && (best < 0 || sc(k) > sc(best))) best = k;
      case (mode)
         2'd0: if (best >= 0) begin acc = 1; aid = best; end
         2'd1: if (int'(req) < NUM_CH && is_cand(int'(req))) begin acc = 1; aid = int'(req); end
         2'd3: begin
            if (!m_locked) begin
               if (best >= 0) begin
                  acc = 1; aid = best; m_locked = 1; m_lock_id = best; m_cnt = 0; m_miss = 0;
               end
            end else if (is_cand(m_lock_id) && m_cnt >= SSB - TOL && m_cnt <= SSB + TOL) begin
               acc = 1; aid = m_lock_id; m_te = m_cnt - SSB; m_cnt = 0; m_miss = 0;
            end else if (tvalid) begin
               if (m_cnt == SSB + TOL) begin
                  m_cnt = TOL; m_miss++;
                  if (m_miss == MAXM) begin m_locked = 0; m_miss = 0; end
               end else m_cnt++;
            end
         end
         default: ;
      endcase
      if (acc) begin m_id = aid; e_vld = 1; e_cfo = !busy; end
   endtask

   task automatic check_all();
      chk("valid", vld, e_vld);
      chk("cfo_start", cfo, e_cfo);
      chk("n_id_2", nid, m_id);
      chk("locked", locked, m_locked);
      chk("miss_cnt", miss, m_miss);
      chk("timing_err", $signed(te), m_te);
      chk("corr_en", cor_en, m_en);
   endtask

   task automatic step(input logic [2:0] pk, input int s0, input int s1, input int s2,
                       input bit tv, input bit bz);
      peak = pk; score = {32'(s2), 32'(s1), 32'(s0)}; tvalid = tv; busy = bz;
      model_cycle();
      @(posedge clk); #1;
      check_all();
   endtask

   task automatic tv_run(input int n);
      repeat (n) step(3'b000, 0, 0, 0, 1, 0);
   endtask

   initial begin
      reset_i = 1; mode = 2'd0; req = '0; thresh = THR;
      peak = '0; score = '0; tvalid = 0; busy = 0;
      model_reset();
      step(3'b000, 0, 0, 0, 0, 0);
      step(3'b000, 0, 0, 0, 0, 0);
      chk("rst_corr_en", cor_en, 0);
      chk("rst_valid", vld, 0);
      reset_i = 0;
      step(3'b000, 0, 0, 0, 0, 0);
      chk("srch_en", cor_en, 1);

      step(3'b101, 80, 0, 120, 0, 0);
      chk("srch_win", nid, 2); chk("srch_vld", vld, 1);
      step(3'b101, 90, 0, 90, 0, 0);
      chk("srch_tie", nid, 0); chk("srch_tie_vld", vld, 1);
      step(3'b010, 0, 40, 0, 0, 0);
      chk("below_thr", vld, 0);

      mode = 2'd1; req = 2'd1;
      step(3'b000, 0, 0, 0, 0, 0);
      step(3'b100, 0, 0, 200, 0, 0);
      chk("fnd_other", vld, 0);
      step(3'b010, 0, 60, 0, 0, 0);
      chk("fnd_id", nid, 1); chk("fnd_vld", vld, 1);
      req = 2'd3;
      step(3'b111, 100, 100, 100, 0, 0);
      chk("fnd_oor", vld, 0);

      mode = 2'd3;
      step(3'b000, 0, 0, 0, 0, 0);
      step(3'b010, 0, 60, 0, 0, 0);
      chk("acq_lock", locked, 1); chk("acq_id", nid, 1);
      tv_run(197);
      step(3'b010, 0, 60, 0, 0, 1);
      chk("te_m3", $signed(te), -3); chk("busy_vld", vld, 1); chk("busy_cfo", cfo, 0);
      tv_run(150);
      step(3'b011, 60, 60, 0, 0, 0);
      chk("early_ign", vld, 0);
      tv_run(61);
      chk("miss1", miss, 1);
      tv_run(201);
      chk("miss2", miss, 2);
      tv_run(201);
      chk("lock_lost", locked, 0); chk("miss_clr", miss, 0);
      step(3'b001, 70, 0, 0, 0, 0);
      chk("reacq", locked, 1); chk("reacq_id", nid, 0);
      tv_run(211);
      chk("miss1b", miss, 1);
      tv_run(200);
      step(3'b001, 70, 0, 0, 1, 0);
      chk("exp_acc_vld", vld, 1); chk("exp_acc_miss", miss, 0);
      chk("exp_te", $signed(te), 10); chk("cfo_pulse", cfo, 1);

      for (int c = 0; c < 3000; c++) begin
         logic [2:0] pk;
         if ($urandom_range(0, 399) == 0) begin
            int r = $urandom_range(0, 5);
            mode = (r >= 3) ? 2'd3 : 2'(r);
         end
         if ($urandom_range(0, 99) == 0) req = 2'($urandom_range(0, 3));
         pk = 3'($urandom_range(1, 7));
         if (!((m_locked && m_mode == 3 && m_cnt >= SSB - 12 && m_cnt <= SSB + 12 &&
                $urandom_range(0, 3) == 0) || $urandom_range(0, 39) == 0))
            pk = 3'b000;
         reset_i = ($urandom_range(0, 999) == 0);
         step(pk, $urandom_range(40, 80), $urandom_range(40, 80), $urandom_range(40, 80),
              $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1);
         reset_i = 0;
      end

      mode = 2'd0;
      step(3'b000, 0, 0, 0, 0, 0);
      mode = 2'd3;
      step(3'b000, 0, 0, 0, 0, 0);
      step(3'b100, 0, 0, 90, 0, 0);
      chk("pre_pause_lock", locked, 1);
      mode = 2'd2;
      step(3'b000, 0, 0, 0, 1, 0);
      chk("pause_en", cor_en, 0); chk("pause_lock", locked, 0);

      mode = 2'd3;
      step(3'b000, 0, 0, 0, 0, 0);
      step(3'b100, 0, 0, 90, 0, 0);
      chk("pre_rst_lock", locked, 1);
      tv_run(195);
      reset_i = 1;
      step(3'b100, 0, 0, 90, 1, 0);
      chk("rst_mid_vld", vld, 0); chk("rst_mid_cfo", cfo, 0);
      chk("rst_mid_lock", locked, 0); chk("rst_mid_en", cor_en, 0);
      chk("rst_mid_id", nid, 0); chk("rst_mid_te", te, 0);
      reset_i = 0;
      step(3'b000, 0, 0, 0, 0, 0);
      chk("post_rst_en", cor_en, 1);
      step(3'b000, 0, 0, 0, 0, 0);
      chk("post_rst_cfo", cfo, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
